// File: rtl/multicycle_ctrl.sv
// ============================================================================
// multicycle_ctrl : main control FSM of the multicycle RV32I core (shared ALU,
// unified memory port, retired-instruction counter).   Rev 1.0
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ResultSrc,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic pc_update, branch;
    logic mem_req_s, ir_write_s, reg_write_s, mem_write_s, illegal_s;

    always_comb begin
        state_d     = FETCH;
        retired_d   = retired_q;
        mem_req_s   = 1'b0;
        AdrSrc      = 1'b0;
        ir_write_s  = 1'b0;
        pc_update   = 1'b0;
        branch      = 1'b0;
        reg_write_s = 1'b0;
        mem_write_s = 1'b0;
        illegal_s   = 1'b0;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        ResultSrc   = 2'b00;
        case (state_q)
            FETCH: begin
                mem_req_s  = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                ir_write_s = mem_ready;
                pc_update  = mem_ready;
                state_d    = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                // ALUOut captures OldPC + imm as a speculative branch target
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXECUTER;
                    OP_ITYPE:          state_d = EXECUTEI;
                    OP_BEQ:            state_d = BEQ;
                    OP_JAL:            state_d = JAL;
                    default: begin
                        state_d   = FETCH;
                        illegal_s = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = opcode[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req_s = 1'b1;
                AdrSrc    = 1'b1;
                state_d   = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                ResultSrc   = 2'b01;
                reg_write_s = 1'b1;
                retired_d   = retired_q + CNT_W'(1);
            end
            MEMWRITE: begin
                mem_req_s   = 1'b1;
                AdrSrc      = 1'b1;
                mem_write_s = mem_ready;
                state_d     = mem_ready ? FETCH : MEMWRITE;
                if (mem_ready) retired_d = retired_q + CNT_W'(1);
            end
            EXECUTER: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                state_d = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                state_d = ALUWB;
            end
            ALUWB: begin
                reg_write_s = 1'b1;
                retired_d   = retired_q + CNT_W'(1);
            end
            BEQ: begin
                ALUSrcA   = 2'b10;
                ALUOp     = 2'b01;
                branch    = 1'b1;
                retired_d = retired_q + CNT_W'(1);
            end
            JAL: begin
                // PC takes the precomputed target; ALU forms the link OldPC + 4
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
                state_d   = ALUWB;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Enables are gated by rst_n so they drop the instant reset asserts
    assign mem_req    = rst_n & mem_req_s;
    assign IRWrite    = rst_n & ir_write_s;
    assign PCWrite    = rst_n & (pc_update | (branch & zero));
    assign RegWrite   = rst_n & reg_write_s;
    assign MemWrite   = rst_n & mem_write_s;
    assign illegal_op = rst_n & illegal_s;
    assign retired    = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// tb_multicycle_ctrl : directed self-checking bench for multicycle_ctrl.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, illegal_op;
    logic [1:0]  ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
    logic [31:0] retired;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .ResultSrc(ResultSrc), .illegal_op(illegal_op), .retired(retired)
    );

    // {mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, ALUSrcA, ALUSrcB, ALUOp, ResultSrc, illegal_op}
    logic [14:0] obs;
    assign obs = {mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite,
                  ALUSrcA, ALUSrcB, ALUOp, ResultSrc, illegal_op};

    localparam logic [14:0] V_RST      = {6'b000000, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0};
    localparam logic [14:0] V_FETCH    = {6'b101100, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0};
    localparam logic [14:0] V_FETCH_W  = {6'b100000, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0};
    localparam logic [14:0] V_DECODE   = {6'b000000, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [14:0] V_DEC_ILL  = {6'b000000, 2'b01, 2'b01, 2'b00, 2'b00, 1'b1};
    localparam logic [14:0] V_MEMADR   = {6'b000000, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [14:0] V_MEMREAD  = {6'b110000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [14:0] V_MEMWB    = {6'b000010, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0};
    localparam logic [14:0] V_MEMWR_W  = {6'b110000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [14:0] V_MEMWR_GO = {6'b110001, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [14:0] V_EXECR    = {6'b000000, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
    localparam logic [14:0] V_EXECI    = {6'b000000, 2'b10, 2'b01, 2'b10, 2'b00, 1'b0};
    localparam logic [14:0] V_ALUWB    = {6'b000010, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [14:0] V_BEQ_T    = {6'b000100, 2'b10, 2'b00, 2'b01, 2'b00, 1'b0};
    localparam logic [14:0] V_BEQ_NT   = {6'b000000, 2'b10, 2'b00, 2'b01, 2'b00, 1'b0};
    localparam logic [14:0] V_JAL      = {6'b000100, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0};

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    task automatic check(input string tag, input logic [14:0] ev, input logic [31:0] er);
        vec_cnt++;
        assert (obs === ev) else begin
            miss_cnt++;
            $error("FAIL %s outputs: observed %b expected %b", tag, obs, ev);
        end
        vec_cnt++;
        assert (retired === er) else begin
            miss_cnt++;
            $error("FAIL %s retired: observed %0d expected %0d", tag, retired, er);
        end
    endtask

    // Drive inputs in the low phase, check after settling, advance one clock.
    task automatic step(input string tag, input logic [6:0] opc, input logic rdy,
                        input logic z, input logic [14:0] ev, input logic [31:0] er);
        opcode    = opc;
        mem_ready = rdy;
        zero      = z;
        #1;
        check(tag, ev, er);
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = OP_R;
        zero      = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        check("reset", V_RST, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // add: 4 cycles
        step("add_fetch",  OP_R, 1'b1, 1'b0, V_FETCH,  32'd0);
        step("add_decode", OP_R, 1'b1, 1'b0, V_DECODE, 32'd0);
        step("add_exec",   OP_R, 1'b1, 1'b0, V_EXECR,  32'd0);
        step("add_wb",     OP_R, 1'b1, 1'b0, V_ALUWB,  32'd0);

        // lw: one fetch wait, two MEMREAD waits
        step("lw_fetch_wait", OP_LW, 1'b0, 1'b0, V_FETCH_W, 32'd1);
        step("lw_fetch",      OP_LW, 1'b1, 1'b0, V_FETCH,   32'd1);
        step("lw_decode",     OP_LW, 1'b1, 1'b0, V_DECODE,  32'd1);
        step("lw_memadr",     OP_LW, 1'b1, 1'b0, V_MEMADR,  32'd1);
        step("lw_rd_wait0",   OP_LW, 1'b0, 1'b0, V_MEMREAD, 32'd1);
        step("lw_rd_wait1",   OP_LW, 1'b0, 1'b0, V_MEMREAD, 32'd1);
        step("lw_rd_done",    OP_LW, 1'b1, 1'b0, V_MEMREAD, 32'd1);
        step("lw_memwb",      OP_LW, 1'b1, 1'b0, V_MEMWB,   32'd1);

        // beq taken
        step("beqt_fetch",  OP_BEQ, 1'b1, 1'b1, V_FETCH,  32'd2);
        step("beqt_decode", OP_BEQ, 1'b1, 1'b1, V_DECODE, 32'd2);
        step("beqt_beq",    OP_BEQ, 1'b1, 1'b1, V_BEQ_T,  32'd2);
        // beq not taken; mem_ready low must not matter outside memory states
        step("beqn_fetch",  OP_BEQ, 1'b1, 1'b0, V_FETCH,  32'd3);
        step("beqn_decode", OP_BEQ, 1'b0, 1'b0, V_DECODE, 32'd3);
        step("beqn_beq",    OP_BEQ, 1'b0, 1'b0, V_BEQ_NT, 32'd3);

        // sw with one wait, then jal
        step("sw_fetch",   OP_SW, 1'b1, 1'b0, V_FETCH,    32'd4);
        step("sw_decode",  OP_SW, 1'b1, 1'b0, V_DECODE,   32'd4);
        step("sw_memadr",  OP_SW, 1'b1, 1'b0, V_MEMADR,   32'd4);
        step("sw_wr_wait", OP_SW, 1'b0, 1'b0, V_MEMWR_W,  32'd4);
        step("sw_wr_go",   OP_SW, 1'b1, 1'b0, V_MEMWR_GO, 32'd4);
        step("jal_fetch",  OP_JAL, 1'b1, 1'b0, V_FETCH,   32'd5);
        step("jal_decode", OP_JAL, 1'b1, 1'b0, V_DECODE,  32'd5);
        step("jal_jal",    OP_JAL, 1'b1, 1'b0, V_JAL,     32'd5);
        step("jal_wb",     OP_JAL, 1'b1, 1'b0, V_ALUWB,   32'd5);

        // I-type ALU
        step("addi_fetch",  OP_I, 1'b1, 1'b0, V_FETCH,  32'd6);
        step("addi_decode", OP_I, 1'b1, 1'b0, V_DECODE, 32'd6);
        step("addi_exec",   OP_I, 1'b1, 1'b0, V_EXECI,  32'd6);
        step("addi_wb",     OP_I, 1'b1, 1'b0, V_ALUWB,  32'd6);

        // illegal opcode: single pulse, back to FETCH, no retire
        step("ill_fetch",  OP_BAD, 1'b1, 1'b0, V_FETCH,   32'd7);
        step("ill_decode", OP_BAD, 1'b1, 1'b0, V_DEC_ILL, 32'd7);
        step("ill_after",  OP_BAD, 1'b0, 1'b0, V_FETCH_W, 32'd7);

        // reset asserted during a store in MEMWRITE
        step("rs_fetch",   OP_SW, 1'b1, 1'b0, V_FETCH,   32'd7);
        step("rs_decode",  OP_SW, 1'b1, 1'b0, V_DECODE,  32'd7);
        step("rs_memadr",  OP_SW, 1'b1, 1'b0, V_MEMADR,  32'd7);
        step("rs_wr_wait", OP_SW, 1'b0, 1'b0, V_MEMWR_W, 32'd7);
        mem_ready = 1'b1;
        #1;
        check("rs_wr_go", V_MEMWR_GO, 32'd7);
        rst_n = 1'b0;
        #1;
        check("rs_async", V_RST, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step("rs_restart", OP_SW, 1'b0, 1'b0, V_FETCH_W, 32'd0);
        step("rs_fetch2",  OP_SW, 1'b1, 1'b0, V_FETCH,   32'd0);
        step("rs_decode2", OP_SW, 1'b1, 1'b0, V_DECODE,  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

`default_nettype wire
